// File: rtl/mfp_irq_ctrl.sv
// MFP-style interrupt controller: NUM_SRC sources, per-source enable,
// pending, in-service, mask, polarity and edge/level trigger.
// Ports: clk, reset_n, clk_en bus qualifier; sel/ds/rw/addr/din/dout/dtack
// byte register bus; iack vector cycle; src raw inputs; irq to the CPU.
module mfp_irq_ctrl #(
  parameter int         NUM_SRC  = 16,
  parameter logic [7:0] SPUR_VEC = 8'h18,
  parameter bit         SYNC_IN  = 1'b1,
  localparam int NBANK  = NUM_SRC / 8,
  localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1,
  localparam int IDX_W  = $clog2(NUM_SRC),
  localparam int ADDR_W = 3 + BANK_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_en,
  input  logic               sel,
  input  logic               ds,
  input  logic               rw,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic               dtack,
  input  logic               iack,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq
);

  typedef logic [NUM_SRC-1:0] vec_t;

  localparam logic [2:0] G_IER = 3'd0;
  localparam logic [2:0] G_IPR = 3'd1;
  localparam logic [2:0] G_ISR = 3'd2;
  localparam logic [2:0] G_IMR = 3'd3;
  localparam logic [2:0] G_POL = 3'd4;
  localparam logic [2:0] G_TRG = 3'd5;
  localparam logic [2:0] G_VR  = 3'd6;
  localparam logic [2:0] G_CTL = 3'd7;
  localparam logic [7:0] VMASK = 8'((1 << IDX_W) - 1);

  vec_t ier_q, ipr_q, isr_q, imr_q, pol_q, trg_q;
  vec_t ier_d, ipr_d, isr_d, imr_d, pol_d, trg_d;
  logic [7:0] vr_q, vr_d, vec_q, vec_d;
  logic seoi_q, seoi_d, gie_q, gie_d;
  logic acc_prev_q, bus_prev_q, iack_prev_q;
  logic dtack_q, irq_q;
  vec_t sync_v, act, act_prev_q, set_v, pend, lane, dwide;
  logic [IDX_W-1:0] hp, his;
  logic his_v, acc, bus, wr_stb, iack_rise, bank0;
  logic [2:0] grp;
  logic [BANK_W-1:0] bank;
  vec_t rsel;
  logic [7:0] rbyte;

  generate
    if (SYNC_IN) begin : g_sync
      vec_t s1_q, s2_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_q <= '0;
          s2_q <= '0;
        end else begin
          s1_q <= src;
          s2_q <= s1_q;
        end
      end
      assign sync_v = s2_q;
    end else begin : g_nosync
      assign sync_v = src;
    end
  endgenerate

  // act is 1 when the source is at its active level
  assign act   = sync_v ^ ~pol_q;
  assign set_v = (trg_q & act) | (~trg_q & act & ~act_prev_q);
  assign pend  = ipr_q & imr_q;

  assign acc       = sel & ~ds;
  assign bus       = acc | iack;
  assign wr_stb    = clk_en & acc & ~rw & ~acc_prev_q;
  assign iack_rise = clk_en & iack & ~iack_prev_q;
  assign grp       = addr[ADDR_W-1:BANK_W];
  assign bank      = addr[BANK_W-1:0];
  assign bank0     = (bank == '0);
  assign dwide     = {NBANK{din}};

  always_comb begin
    lane = '0;
    for (int b = 0; b < NBANK; b++)
      if (bank == BANK_W'(b)) lane[b*8 +: 8] = 8'hFF;
  end

  always_comb begin
    hp    = '0;
    his   = '0;
    his_v = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pend[i]) hp = IDX_W'(i);
      if (isr_q[i]) begin
        his   = IDX_W'(i);
        his_v = 1'b1;
      end
    end
  end

  always_comb begin
    ier_d  = ier_q;
    ipr_d  = ipr_q;
    isr_d  = isr_q;
    imr_d  = imr_q;
    pol_d  = pol_q;
    trg_d  = trg_q;
    vr_d   = vr_q;
    vec_d  = vec_q;
    seoi_d = seoi_q;
    gie_d  = gie_q;
    if (wr_stb) begin
      unique case (grp)
        G_IER: ier_d = (ier_q & ~lane) | (dwide & lane);
        G_IPR: ipr_d = ipr_q & ~(lane & ~dwide);
        G_ISR: isr_d = isr_q & ~(lane & ~dwide);
        G_IMR: imr_d = (imr_q & ~lane) | (dwide & lane);
        G_POL: pol_d = (pol_q & ~lane) | (dwide & lane);
        G_TRG: trg_d = (trg_q & ~lane) | (dwide & lane);
        G_VR:  if (bank0) vr_d = din;
        G_CTL: if (bank0) begin
          seoi_d = din[0];
          gie_d  = din[1];
        end
      endcase
    end
    ipr_d = ipr_d & ier_d;
    if (iack_rise) begin
      if (|pend) begin
        vec_d     = (vr_q & ~VMASK) | 8'(hp);
        ipr_d[hp] = 1'b0;
        if (seoi_q) isr_d[hp] = 1'b1;
      end else begin
        vec_d = SPUR_VEC;
      end
    end
    // a new event in the same cycle as a clear wins
    ipr_d = ipr_d | (set_v & ier_d);
  end

  always_comb begin
    rsel = '0;
    unique case (grp)
      G_IER: rsel = ier_q;
      G_IPR: rsel = ipr_q;
      G_ISR: rsel = isr_q;
      G_IMR: rsel = imr_q;
      G_POL: rsel = pol_q;
      G_TRG: rsel = trg_q;
      G_VR:  rsel = '0;
      G_CTL: rsel = '0;
    endcase
    rbyte = '0;
    for (int b = 0; b < NBANK; b++)
      if (bank == BANK_W'(b)) rbyte = rsel[b*8 +: 8];
    if (grp == G_VR)  rbyte = bank0 ? vr_q : 8'h00;
    if (grp == G_CTL) rbyte = bank0 ? {6'b0, gie_q, seoi_q} : 8'h00;
  end

  always_comb begin
    dout = 8'h00;
    if (acc & rw) dout = rbyte;
    else if (iack) dout = vec_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ier_q       <= '0;
      ipr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '0;
      pol_q       <= '0;
      trg_q       <= '0;
      vr_q        <= '0;
      vec_q       <= SPUR_VEC;
      seoi_q      <= 1'b0;
      gie_q       <= 1'b0;
      act_prev_q  <= '0;
      acc_prev_q  <= 1'b0;
      bus_prev_q  <= 1'b0;
      iack_prev_q <= 1'b0;
      dtack_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ier_q      <= ier_d;
      ipr_q      <= ipr_d;
      isr_q      <= isr_d;
      imr_q      <= imr_d;
      pol_q      <= pol_d;
      trg_q      <= trg_d;
      vr_q       <= vr_d;
      vec_q      <= vec_d;
      seoi_q     <= seoi_d;
      gie_q      <= gie_d;
      act_prev_q <= act;
      irq_q      <= gie_q & (|pend) & (~his_v | (hp > his));
      if (clk_en) begin
        acc_prev_q  <= acc;
        iack_prev_q <= iack;
        bus_prev_q  <= bus;
        if (bus & bus_prev_q) dtack_q <= 1'b1;
        else if (!bus) dtack_q <= 1'b0;
      end
    end
  end

  assign dtack = dtack_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Scoreboard bench for mfp_irq_ctrl (16 sources, random + directed)
// plus a directed 32-source instance.
module tb_mfp_irq_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clk_en = 1'b1;
  logic sel = 1'b0, ds = 1'b1, rw = 1'b1, iack = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] din = '0;
  logic [15:0] src = '0;
  logic [7:0] dout;
  logic dtack, irq;
  logic sel2 = 1'b0, iack2 = 1'b0;
  logic [4:0] addr2 = '0;
  logic [31:0] src2 = '0;
  logic [7:0] dout2;
  logic dtack2, irq2;
  int total = 0, bad = 0;
  bit en_rand = 1'b0;

  mfp_irq_ctrl #(.NUM_SRC(16)) u16 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .sel(sel), .ds(ds), .rw(rw), .addr(addr),
    .din(din), .dout(dout), .dtack(dtack),
    .iack(iack), .src(src), .irq(irq)
  );

  mfp_irq_ctrl #(.NUM_SRC(32)) u32 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .sel(sel2), .ds(ds), .rw(rw), .addr(addr2),
    .din(din), .dout(dout2), .dtack(dtack2),
    .iack(iack2), .src(src2), .irq(irq2)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk); #1;
    clk_en = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endfunction

  typedef struct {
    string      nm;
    bit         rd;
    logic [7:0] v;
    logic       irq;
  } exp_t;
  exp_t sbq[$];

  function automatic void push(string nm, bit r, logic [7:0] v, logic q);
    exp_t e;
    e.nm = nm; e.rd = r; e.v = v; e.irq = q;
    sbq.push_back(e);
  endfunction

  logic dt_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (dtack === 1'b1 && !dt_prev) begin
      if (sbq.size() == 0) chk("unexpected dtack", 1, 0);
      else begin
        e = sbq.pop_front();
        chk(e.nm, dout, e.v);
        if (e.rd) chk({e.nm, "/irq"}, irq, e.irq);
      end
    end
    dt_prev = (dtack === 1'b1);
  end

  // reference model of the 16-source instance
  logic [15:0] m_ier, m_ipr, m_isr, m_imr, m_pol, m_trg;
  logic [7:0] m_vr;
  logic m_s, m_gie;

  function automatic void m_reset();
    m_ier = '0; m_ipr = '0; m_isr = '0; m_imr = '0;
    m_pol = '0; m_trg = '0; m_vr = '0; m_s = 0; m_gie = 0;
  endfunction

  function automatic logic [15:0] m_act(logic [15:0] s, logic [15:0] p);
    return ~(s ^ p);
  endfunction

  function automatic int top(logic [15:0] v);
    int r = -1;
    for (int i = 0; i < 16; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic m_irq();
    int h = top(m_ipr & m_imr);
    return m_gie && h >= 0 && h > top(m_isr);
  endfunction

  function automatic void m_level();
    m_ipr |= m_ier & m_trg & m_act(src, m_pol);
  endfunction

  task automatic wait16(logic want, string nm);
    int n = 0;
    while (dtack !== want && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (dtack !== want) chk(nm, dtack, want);
  endtask

  task automatic bus16(bit r, bit a, int g, int b, logic [7:0] d);
    @(posedge clk); #1;
    if (a) iack = 1'b1;
    else begin
      sel = 1'b1; ds = 1'b0; rw = r;
      addr = {3'(g), 1'(b)}; din = d;
    end
    wait16(1'b1, "dtack rise");
    @(posedge clk); #1;
    sel = 1'b0; ds = 1'b1; rw = 1'b1; iack = 1'b0;
    wait16(1'b0, "dtack fall");
  endtask

  task automatic wr(int g, int b, logic [7:0] d);
    logic [15:0] so;
    push("wr dout", 0, 8'h00, 0);
    bus16(0, 0, g, b, d);
    so = m_act(src, m_pol);
    case (g)
      0: begin m_ier[b*8 +: 8] = d; m_ipr &= m_ier; end
      1: m_ipr[b*8 +: 8] &= d;
      2: m_isr[b*8 +: 8] &= d;
      3: m_imr[b*8 +: 8] = d;
      4: begin
        m_pol[b*8 +: 8] = d;
        m_ipr |= m_ier & ~m_trg & m_act(src, m_pol) & ~so;
      end
      5: m_trg[b*8 +: 8] = d;
      6: if (b == 0) m_vr = d;
      default: if (b == 0) begin m_s = d[0]; m_gie = d[1]; end
    endcase
    m_level();
  endtask

  task automatic rd(int g, int b, string nm);
    logic [7:0] e;
    case (g)
      0: e = m_ier[b*8 +: 8];
      1: e = m_ipr[b*8 +: 8];
      2: e = m_isr[b*8 +: 8];
      3: e = m_imr[b*8 +: 8];
      4: e = m_pol[b*8 +: 8];
      5: e = m_trg[b*8 +: 8];
      6: e = (b == 0) ? m_vr : 8'h00;
      default: e = (b == 0) ? {6'b0, m_gie, m_s} : 8'h00;
    endcase
    push(nm, 1, e, m_irq());
    bus16(1, 0, g, b, 8'h00);
  endtask

  task automatic ack(string nm);
    int h = top(m_ipr & m_imr);
    logic [7:0] e;
    if (h >= 0) begin
      e = {m_vr[7:4], 4'(h)};
      m_ipr[h] = 1'b0;
      if (m_s) m_isr[h] = 1'b1;
    end else e = 8'h18;
    m_level();
    push(nm, 0, e, 0);
    bus16(0, 1, 0, 0, 8'h00);
  endtask

  task automatic set_src(logic [15:0] n);
    logic [15:0] so, sn;
    so = m_act(src, m_pol);
    sn = m_act(n, m_pol);
    m_ipr |= m_ier & ~m_trg & sn & ~so;
    @(posedge clk); #1 src = n;
    repeat (5) @(posedge clk);
    m_level();
  endtask

  // edge on src[7] reaches the pending logic on the same clock as
  // an IPR write that clears bit 7
  task automatic race7();
    logic [15:0] so, n;
    so = m_act(src, m_pol);
    n = src | 16'h0080;
    @(posedge clk); #1 src = n;
    @(posedge clk);
    push("race7 wr", 0, 8'h00, 0);
    bus16(0, 0, 1, 0, 8'h7F);
    m_ipr[7:0] &= 8'h7F;
    m_ipr |= m_ier & ~m_trg & m_act(n, m_pol) & ~so;
    m_level();
  endtask

  task automatic bus32(bit r, bit a, int g, int b, logic [7:0] d,
                       output logic [7:0] got);
    int n = 0;
    @(posedge clk); #1;
    if (a) iack2 = 1'b1;
    else begin
      sel2 = 1'b1; ds = 1'b0; rw = r;
      addr2 = {3'(g), 2'(b)}; din = d;
    end
    while (dtack2 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    if (dtack2 !== 1'b1) chk("u32 dtack rise", dtack2, 1);
    @(negedge clk);
    got = dout2;
    @(posedge clk); #1;
    sel2 = 1'b0; ds = 1'b1; rw = 1'b1; iack2 = 1'b0;
    n = 0;
    while (dtack2 !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
    if (dtack2 !== 1'b0) chk("u32 dtack fall", dtack2, 0);
  endtask

  initial begin
    logic [7:0] got;
    int n;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset dtack", dtack, 0);
    chk("reset irq", irq, 0);
    chk("reset dout", dout, 0);
    @(negedge clk) reset_n = 1'b1;

    ack("spur after reset");
    for (int b = 0; b < 2; b++) wr(4, b, 8'hFF);
    for (int b = 0; b < 2; b++) wr(0, b, 8'hFF);
    for (int b = 0; b < 2; b++) wr(3, b, 8'hFF);
    wr(6, 0, 8'h40);
    wr(7, 0, 8'h03);
    rd(7, 0, "ctl");
    rd(6, 1, "vr bank1");

    set_src(16'h2000);
    rd(1, 1, "ipr13 set");
    ack("vec 4D");
    rd(2, 1, "isr13 set");
    rd(1, 1, "ipr13 clr");
    set_src(src | 16'h0020);
    set_src(src & ~16'h0020);
    rd(1, 0, "ipr5 blocked");
    set_src(src | 16'h4000);
    set_src(src & ~16'h4000);
    rd(1, 1, "ipr14 irq");
    wr(2, 1, 8'hDF);
    rd(2, 1, "isr13 eoi");
    ack("vec 14");
    ack("vec 5");
    wr(2, 0, 8'h00);
    wr(2, 1, 8'h00);
    set_src(16'h0000);

    wr(5, 0, 8'h04);
    set_src(16'h0004);
    wr(1, 0, 8'hFB);
    rd(1, 0, "level repend");
    set_src(16'h0000);
    wr(1, 0, 8'hFB);
    rd(1, 0, "level cleared");
    wr(5, 0, 8'h00);

    race7();
    rd(1, 0, "race7 set wins");
    set_src(16'h0000);

    wr(3, 0, 8'h00);
    wr(3, 1, 8'h00);
    ack("imr0 spur");
    rd(1, 0, "ipr kept");

    en_rand = 1'b1;
    for (int k = 0; k < 220; k++) begin
      int op = $urandom_range(0, 9);
      if (op < 3) set_src(src ^ (16'h1 << $urandom_range(0, 15)));
      else if (op < 6) wr($urandom_range(0, 7), $urandom_range(0, 1),
                          8'($urandom));
      else if (op < 8) rd($urandom_range(0, 7), $urandom_range(0, 1), "rnd rd");
      else ack("rnd iack");
    end
    en_rand = 1'b0;
    repeat (4) @(posedge clk);
    chk("scoreboard drained", sbq.size(), 0);

    for (int b = 0; b < 4; b++) bus32(0, 0, 4, b, 8'hFF, got);
    bus32(0, 0, 0, 3, 8'h80, got);
    bus32(0, 0, 3, 3, 8'h80, got);
    bus32(0, 0, 6, 0, 8'hA0, got);
    bus32(0, 0, 7, 0, 8'h03, got);
    @(posedge clk); #1 src2[31] = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("u32 irq31", irq2, 1);
    bus32(1, 0, 1, 3, 8'h00, got);
    chk("u32 ipr bank3", got, 8'h80);
    bus32(0, 1, 0, 0, 8'h00, got);
    chk("u32 vec BF", got, 8'hBF);
    bus32(1, 0, 2, 3, 8'h00, got);
    chk("u32 isr bank3", got, 8'h80);
    bus32(1, 0, 1, 3, 8'h00, got);
    chk("u32 ipr after iack", got, 8'h00);
    chk("u32 irq blocked", irq2, 0);

    bus32(0, 0, 2, 3, 8'h00, got);
    bus32(0, 0, 7, 0, 8'h02, got);
    bus32(0, 0, 0, 3, 8'hE0, got);
    bus32(0, 0, 3, 3, 8'hE0, got);
    @(posedge clk); #1 src2[30:29] = 2'b11;
    repeat (6) @(posedge clk);
    #1 chk("u32 irq30", irq2, 1);
    @(posedge clk); #1 iack2 = 1'b1;
    n = 0;
    while (dtack2 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk("u32 mid dtack", dtack2, 1);
    @(negedge clk);
    chk("u32 vec BE", dout2, 8'hBE);
    chk("u32 irq29 left", irq2, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst dtack", dtack2, 0);
    chk("async rst irq", irq2, 0);
    chk("async rst vec", dout2, 8'h18);
    @(posedge clk); #1 iack2 = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    bus32(1, 0, 1, 3, 8'h00, got);
    chk("u32 ipr after rst", got, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
